// File: rtl/combat_controller.sv
// combat_controller
//   Per-frame game scheduler between the VGA timing and the two player FSMs.
//   It turns frame_end (or a single-step button edge in debug mode) into a
//   one-cycle game_tick enable. After each tick it resolves hitbox-vs-hurtbox
//   overlap for both players, applies damage and hitstun, and runs the round
//   state machine (COUNTDOWN -> FIGHT <-> EVAL -> OVER).
//
// Ports
//   clk, rst            : system clock, synchronous active-high reset
//   frame_end           : one-cycle pulse at the last visible pixel
//   step_mode, step_btn : debug single-step select and debounced button level
//   restart             : one-cycle pulse, only acted on in OVER
//   p{1,2}_hit_*        : attack box corners (inclusive) and live flag
//   p{1,2}_hurt_*       : hurtbox corners (inclusive)
//   game_tick           : one-cycle enable to both players
//   p{1,2}_health       : current health
//   p{1,2}_stun         : stun counter nonzero (combinational)
//   p{1,2}_hit_evt      : one-cycle pulse, that player was hit
//   round_state         : 0=COUNTDOWN 1=FIGHT 2=EVAL 3=OVER
//   winner              : 0=none 1=P1 2=P2 3=draw

module combat_controller #(
  parameter int unsigned HEALTH_MAX       = 100,
  parameter int unsigned DAMAGE           = 10,
  parameter int unsigned HITSTUN_FRAMES   = 15,
  parameter int unsigned COUNTDOWN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_end,
  input  logic       step_mode,
  input  logic       step_btn,
  input  logic       restart,
  input  logic [9:0] p1_hit_x1,
  input  logic [9:0] p1_hit_x2,
  input  logic [9:0] p1_hit_y1,
  input  logic [9:0] p1_hit_y2,
  input  logic       p1_hit_active,
  input  logic [9:0] p1_hurt_x1,
  input  logic [9:0] p1_hurt_x2,
  input  logic [9:0] p1_hurt_y1,
  input  logic [9:0] p1_hurt_y2,
  input  logic [9:0] p2_hit_x1,
  input  logic [9:0] p2_hit_x2,
  input  logic [9:0] p2_hit_y1,
  input  logic [9:0] p2_hit_y2,
  input  logic       p2_hit_active,
  input  logic [9:0] p2_hurt_x1,
  input  logic [9:0] p2_hurt_x2,
  input  logic [9:0] p2_hurt_y1,
  input  logic [9:0] p2_hurt_y2,
  output logic       game_tick,
  output logic [6:0] p1_health,
  output logic [6:0] p2_health,
  output logic       p1_stun,
  output logic       p2_stun,
  output logic       p1_hit_evt,
  output logic       p2_hit_evt,
  output logic [1:0] round_state,
  output logic [1:0] winner
);

  localparam int STUN_W = $clog2(HITSTUN_FRAMES + 1);
  localparam int CD_W   = $clog2(COUNTDOWN_FRAMES + 1);

  localparam logic [1:0] ST_COUNTDOWN = 2'd0;
  localparam logic [1:0] ST_FIGHT     = 2'd1;
  localparam logic [1:0] ST_EVAL      = 2'd2;
  localparam logic [1:0] ST_OVER      = 2'd3;

  logic [1:0]        state;
  logic [CD_W-1:0]   cd_cnt;
  logic [STUN_W-1:0] p1_stun_cnt;
  logic [STUN_W-1:0] p2_stun_cnt;
  logic              p1_landed;
  logic              p2_landed;
  logic              step_btn_d;
  logic              tick_req;
  logic              p1_lands;
  logic              p2_lands;
  logic [6:0]        p1_health_nxt;
  logic [6:0]        p2_health_nxt;

  // Inclusive axis-aligned box intersection; touching edges count as a hit.
  function automatic logic overlap(
    input logic [9:0] ax1, input logic [9:0] ax2,
    input logic [9:0] ay1, input logic [9:0] ay2,
    input logic [9:0] bx1, input logic [9:0] bx2,
    input logic [9:0] by1, input logic [9:0] by2
  );
    return (ax1 <= bx2) && (bx1 <= ax2) && (ay1 <= by2) && (by1 <= ay2);
  endfunction

  // Health subtraction done at 32 bits so a DAMAGE larger than the health
  // range still clamps cleanly to zero instead of wrapping.
  function automatic logic [6:0] take_damage(input logic [6:0] health);
    logic [31:0] ext;
    ext = {25'd0, health};
    if (ext <= DAMAGE) return 7'd0;
    return 7'(ext - DAMAGE);
  endfunction

  // Tick source: in step mode only the rising edge of the button counts,
  // so holding it down advances the game exactly once.
  assign tick_req = step_mode ? (step_btn & ~step_btn_d) : frame_end;

  // A stunned defender cannot be hit, and an attacker whose latch is set has
  // already connected with the current attack.
  assign p1_lands = p1_hit_active & ~p1_landed & (p2_stun_cnt == '0) &
                    overlap(p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
                            p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2);
  assign p2_lands = p2_hit_active & ~p2_landed & (p1_stun_cnt == '0) &
                    overlap(p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
                            p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2);

  assign p1_health_nxt = p2_lands ? take_damage(p1_health) : p1_health;
  assign p2_health_nxt = p1_lands ? take_damage(p2_health) : p2_health;

  assign p1_stun     = (p1_stun_cnt != '0);
  assign p2_stun     = (p2_stun_cnt != '0);
  assign round_state = state;

  // Round state machine plus all registered outputs. Pulse outputs default
  // low every cycle; in FIGHT the tick is issued one cycle after the request
  // and the following cycle moves to EVAL, so requests landing in the tick
  // or EVAL cycle are simply not looked at.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_COUNTDOWN;
      cd_cnt      <= CD_W'(COUNTDOWN_FRAMES);
      p1_health   <= 7'(HEALTH_MAX);
      p2_health   <= 7'(HEALTH_MAX);
      p1_stun_cnt <= '0;
      p2_stun_cnt <= '0;
      p1_landed   <= 1'b0;
      p2_landed   <= 1'b0;
      winner      <= 2'd0;
      game_tick   <= 1'b0;
      p1_hit_evt  <= 1'b0;
      p2_hit_evt  <= 1'b0;
      step_btn_d  <= 1'b0;
    end else begin
      step_btn_d <= step_btn;
      game_tick  <= 1'b0;
      p1_hit_evt <= 1'b0;
      p2_hit_evt <= 1'b0;

      case (state)
        ST_COUNTDOWN: begin
          if (tick_req) begin
            cd_cnt <= cd_cnt - CD_W'(1);
            if (cd_cnt == CD_W'(1)) state <= ST_FIGHT;
          end
        end

        ST_FIGHT: begin
          if (game_tick) begin
            state <= ST_EVAL;
            if (p1_stun_cnt != '0) p1_stun_cnt <= p1_stun_cnt - STUN_W'(1);
            if (p2_stun_cnt != '0) p2_stun_cnt <= p2_stun_cnt - STUN_W'(1);
          end else if (tick_req) begin
            game_tick <= 1'b1;
          end
        end

        ST_EVAL: begin
          if (!p1_hit_active)  p1_landed <= 1'b0;
          else if (p1_lands)   p1_landed <= 1'b1;
          if (!p2_hit_active)  p2_landed <= 1'b0;
          else if (p2_lands)   p2_landed <= 1'b1;

          if (p1_lands) begin
            p2_stun_cnt <= STUN_W'(HITSTUN_FRAMES);
            p2_hit_evt  <= 1'b1;
          end
          if (p2_lands) begin
            p1_stun_cnt <= STUN_W'(HITSTUN_FRAMES);
            p1_hit_evt  <= 1'b1;
          end

          p1_health <= p1_health_nxt;
          p2_health <= p2_health_nxt;

          if (p1_health_nxt == 7'd0 && p2_health_nxt == 7'd0) begin
            state  <= ST_OVER;
            winner <= 2'd3;
          end else if (p1_health_nxt == 7'd0) begin
            state  <= ST_OVER;
            winner <= 2'd2;
          end else if (p2_health_nxt == 7'd0) begin
            state  <= ST_OVER;
            winner <= 2'd1;
          end else begin
            state <= ST_FIGHT;
          end
        end

        default: begin
          if (restart) begin
            state       <= ST_COUNTDOWN;
            cd_cnt      <= CD_W'(COUNTDOWN_FRAMES);
            p1_health   <= 7'(HEALTH_MAX);
            p2_health   <= 7'(HEALTH_MAX);
            p1_stun_cnt <= '0;
            p2_stun_cnt <= '0;
            p1_landed   <= 1'b0;
            p2_landed   <= 1'b0;
            winner      <= 2'd0;
          end
        end
      endcase
    end
  end

endmodule
